kpscan: RTL and testbench

Keypad column scanner and debouncer that sits directly upstream of the keypad decoder. It drives the 4×4 matrix columns active-low one at a time and synchronises and debounces the active-low row inputs. It then presents a stable, latched row/column pair to the decoder, with a one-cycle press event and a held level. Only one key is recognised at a time; ambiguous row patterns are rejected.

---
 rtl/kpscan.sv | 189 ++++++++++++++++++
 tb/tb_kpscan.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/kpscan.sv
// kpscan: 4x4 keypad column scanner with a two-flop row synchroniser and press/release debounce.
// Optional auto-repeat while a key is held is built only when KPSCAN_REPEAT_EN is defined.
//   state    | meaning
//   SCAN     | columns rotate each tick, looking for a single low row
//   DEBOUNCE | column frozen, counting tick samples that match the captured row
//   HELD     | key accepted, counting consecutive all-high tick samples for release
module kpscan #(
  parameter int SCAN_DIV     = 50000,
  parameter int DB_CNT       = 20,
  parameter int REPEAT_TICKS = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] kpr,
  output logic [3:0] kpc,
  output logic [3:0] kp_row,
  output logic [3:0] kp_col,
  output logic       key_valid,
  output logic       key_held
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DB_CNT + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);

  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("kpscan: SCAN_DIV must be >= 4");
  end
  if (DB_CNT < 2) begin : g_bad_db_cnt
    $error("kpscan: DB_CNT must be >= 2");
  end
  if (REPEAT_TICKS < 1) begin : g_bad_repeat
    $error("kpscan: REPEAT_TICKS must be >= 1");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t          state, state_nxt;
  logic [3:0]      kpr_m, kpr_s;
  logic [TW-1:0]   div_cnt;
  logic            tick;
  logic            one_low;
  logic [3:0]      kpc_rot;
  logic [3:0]      kpc_nxt, cap_row, cap_row_nxt, cap_col, cap_col_nxt;
  logic [3:0]      kp_row_nxt, kp_col_nxt;
  logic [CW-1:0]   db_cnt, db_cnt_nxt, rel_cnt, rel_cnt_nxt;
  logic            key_valid_nxt, key_held_nxt;
`ifdef KPSCAN_REPEAT_EN
  logic [RW-1:0]   rep_cnt, rep_cnt_nxt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      kpr_m   <= 4'b1111;
      kpr_s   <= 4'b1111;
      div_cnt <= '0;
    end else begin
      kpr_m   <= kpr;
      kpr_s   <= kpr_m;
      div_cnt <= tick ? '0 : div_cnt + TW'(1);
    end
  end

  assign tick    = (div_cnt == TW'(SCAN_DIV - 1));
  assign kpc_rot = {kpc[0], kpc[3:1]};

  // Two keys in one column pull several rows low; that is treated as no key.
  always_comb begin
    case (kpr_s)
      4'b0111, 4'b1011, 4'b1101, 4'b1110: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    kpc_nxt       = kpc;
    cap_row_nxt   = cap_row;
    cap_col_nxt   = cap_col;
    db_cnt_nxt    = db_cnt;
    rel_cnt_nxt   = rel_cnt;
    kp_row_nxt    = kp_row;
    kp_col_nxt    = kp_col;
    key_valid_nxt = 1'b0;
`ifdef KPSCAN_REPEAT_EN
    rep_cnt_nxt   = rep_cnt;
`endif
    case (state)
      SCAN: begin
        if (tick) begin
          if (one_low) begin
            cap_row_nxt = kpr_s;
            cap_col_nxt = kpc;
            db_cnt_nxt  = CW'(1);
            state_nxt   = DEBOUNCE;
          end else begin
            kpc_nxt = kpc_rot;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (kpr_s == cap_row) begin
            if (db_cnt == CW'(DB_CNT - 1)) begin
              state_nxt     = HELD;
              kp_row_nxt    = cap_row;
              kp_col_nxt    = cap_col;
              key_valid_nxt = 1'b1;
              rel_cnt_nxt   = '0;
`ifdef KPSCAN_REPEAT_EN
              rep_cnt_nxt   = '0;
`endif
            end else begin
              db_cnt_nxt = db_cnt + CW'(1);
            end
          end else begin
            state_nxt = SCAN;
            kpc_nxt   = kpc_rot;
          end
        end
      end
      HELD: begin
        if (tick) begin
          if (kpr_s == 4'b1111) begin
            if (rel_cnt == CW'(DB_CNT - 1)) begin
              state_nxt   = SCAN;
              kpc_nxt     = kpc_rot;
              kp_row_nxt  = 4'b1111;
              kp_col_nxt  = 4'b1111;
              rel_cnt_nxt = '0;
            end else begin
              rel_cnt_nxt = rel_cnt + CW'(1);
            end
          end else begin
            rel_cnt_nxt = '0;
          end
        end
`ifdef KPSCAN_REPEAT_EN
        // Repeat only counts ticks where the key still reads pressed and no release is pending.
        if (rel_cnt != '0) begin
          rep_cnt_nxt = '0;
        end else if (tick && kpr_s != 4'b1111) begin
          if (rep_cnt == RW'(REPEAT_TICKS - 1)) begin
            rep_cnt_nxt   = '0;
            key_valid_nxt = 1'b1;
          end else begin
            rep_cnt_nxt = rep_cnt + RW'(1);
          end
        end
`endif
      end
      default: state_nxt = SCAN;
    endcase
    key_held_nxt = (state_nxt == HELD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      kpc       <= 4'b0111;
      cap_row   <= 4'b1111;
      cap_col   <= 4'b1111;
      db_cnt    <= '0;
      rel_cnt   <= '0;
      kp_row    <= 4'b1111;
      kp_col    <= 4'b1111;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KPSCAN_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      kpc       <= kpc_nxt;
      cap_row   <= cap_row_nxt;
      cap_col   <= cap_col_nxt;
      db_cnt    <= db_cnt_nxt;
      rel_cnt   <= rel_cnt_nxt;
      kp_row    <= kp_row_nxt;
      kp_col    <= kp_col_nxt;
      key_valid <= key_valid_nxt;
      key_held  <= key_held_nxt;
`ifdef KPSCAN_REPEAT_EN
      rep_cnt   <= rep_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_kpscan.sv
// Directed bench for kpscan with SCAN_DIV=4, DB_CNT=3; a keypad model pulls key_row low only
// while key_col is driven. Cycle numbers count posedges after reset is released.
module tb_kpscan;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] kpr, kpc, kp_row, kp_col;
  logic       key_valid, key_held;
  logic [3:0] key_row = 4'hF;
  logic [3:0] key_col = 4'h0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int pulses = 0;
  int first_pulse = -1;
  int pulses_saved;

  logic [3:0] rot [4] = '{4'h7, 4'hB, 4'hD, 4'hE};

  kpscan #(.SCAN_DIV(4), .DB_CNT(3), .REPEAT_TICKS(2)) dut (
    .clk(clk), .reset(reset), .kpr(kpr), .kpc(kpc),
    .kp_row(kp_row), .kp_col(kp_col), .key_valid(key_valid), .key_held(key_held)
  );

  assign kpr = (kpc == key_col) ? key_row : 4'hF;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (key_valid === 1'b1) begin
      pulses++;
      if (first_pulse < 0) first_pulse = cyc;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    pulses = 0;
    first_pulse = -1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_kpc"},    kpc,       4'h7);
    chk({tag, "_row"},    kp_row,    4'hF);
    chk({tag, "_col"},    kp_col,    4'hF);
    chk({tag, "_valid"},  key_valid, 1'b0);
    chk({tag, "_held"},   key_held,  1'b0);
  endtask

  initial begin
    // reset and idle scan
    do_reset();
    chk_rst("rst");
    for (int i = 0; i < 16; i++) begin
      step();
      chk("idle_kpc", kpc, rot[(cyc / 4) % 4]);
    end
    chk("idle_pulses", pulses, 0);
    chk("idle_row", kp_row, 4'hF);
    chk("idle_held", key_held, 1'b0);

    // clean press at row 1011 / column 1101: captured at 12, accepted at edge 20
    key_col = 4'hD;
    key_row = 4'hB;
    do_reset();
    run_to(16);
    chk("press_frozen_kpc", kpc, 4'hD);
    run_to(19);
    chk("press_held_early", key_held, 1'b0);
    chk("press_no_early_pulse", pulses, 0);
    step();
    chk("press_valid", key_valid, 1'b1);
    chk("press_held", key_held, 1'b1);
    chk("press_row", kp_row, 4'hB);
    chk("press_col", kp_col, 4'hD);
    step();
    chk("press_valid_width", key_valid, 1'b0);
    run_to(40);
    chk("press_first_pulse", first_pulse, 20);
`ifdef KPSCAN_REPEAT_EN
    chk("press_pulse_count", pulses, 3);
`else
    chk("press_pulse_count", pulses, 1);
`endif
    chk("press_hold_kpc", kpc, 4'hD);
    chk("press_hold_row", kp_row, 4'hB);

    // release with chatter: ticks at 24 (1111), 28 (1011), then 32, 36, 40 all-high
    do_reset();
    run_to(21);
    key_row = 4'hF;
    run_to(25);
    key_row = 4'hB;
    run_to(29);
    key_row = 4'hF;
    run_to(39);
    chk("rel_still_held", key_held, 1'b1);
    chk("rel_still_row", kp_row, 4'hB);
    step();
    chk("rel_held", key_held, 1'b0);
    chk("rel_row", kp_row, 4'hF);
    chk("rel_col", kp_col, 4'hF);
    chk("rel_kpc", kpc, 4'hE);
    run_to(44);
    chk("rel_rescan_kpc", kpc, 4'h7);

    // bounce: row low for ticks 12 and 16 only, mismatch at 20
    key_col = 4'hD;
    key_row = 4'hB;
    do_reset();
    run_to(15);
    key_row = 4'hF;
    run_to(19);
    chk("bounce_frozen_kpc", kpc, 4'hD);
    step();
    chk("bounce_kpc_adv", kpc, 4'hE);
    run_to(40);
    chk("bounce_pulses", pulses, 0);
    chk("bounce_held", key_held, 1'b0);
    chk("bounce_row", kp_row, 4'hF);

    // ambiguous rows 0011 on column 0111: scan keeps moving
    key_col = 4'h7;
    key_row = 4'h3;
    do_reset();
    run_to(4);
    chk("amb_kpc1", kpc, 4'hB);
    run_to(8);
    chk("amb_kpc2", kpc, 4'hD);
    run_to(30);
    chk("amb_pulses", pulses, 0);
    chk("amb_held", key_held, 1'b0);

    // reset during DEBOUNCE, then during HELD
    key_col = 4'hD;
    key_row = 4'hB;
    do_reset();
    run_to(14);
    reset = 1'b1;
    step();
    chk_rst("mrst_db");
    chk("mrst_db_pulses", pulses, 0);
    do_reset();
    run_to(20);
    chk("mrst_redebounce_valid", key_valid, 1'b1);
    chk("mrst_redebounce_first", first_pulse, 20);
    run_to(25);
    reset = 1'b1;
    step();
    chk_rst("mrst_held");
    reset = 1'b0;
    pulses_saved = pulses;
    run_to(36);
    chk("mrst_no_spurious", pulses, pulses_saved);
    chk("mrst_held_after", key_held, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
